mac_sequencer: RTL and testbench

MAC_SEQUENCER -- requirements
Module: mac_sequencer

---
 rtl/mac_sequencer.sv | 101 ++++++++++
 tb/tb_mac_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_sequencer.sv
// Dot-product sequencer: streams operand pairs into an external MAC, drains its
// pipeline and captures the accumulated result with a one-cycle strobe.
module mac_sequencer #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 16,
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic              mac_clr,
    input  logic [ACC_W-1:0]  mac_out,
    output logic [ACC_W-1:0]  res,
    output logic              res_valid
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CLEAR  = 3'd1;
    localparam logic [2:0] STREAM = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    localparam int DRAIN_W = $clog2(MAC_LAT + 1) + 1;

    logic [2:0]         state;
    logic [LEN_W-1:0]   count;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               xfer;

    // NOTE: these are pure decodes of the registered state, so they carry no
    // storage and cannot infer latches; every output is fully assigned here.
    always_comb begin
        busy      = (state != IDLE);
        in_ready  = (state == STREAM);
        mac_clr   = (state == CLEAR);
        res_valid = (state == DONE);
        xfer      = in_valid && in_ready;
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            drain_cnt <= '0;
            mac_a     <= '0;
            mac_b     <= '0;
            res       <= '0;
        end else begin
            // Non-transfer edges feed a zero product so idle cycles add nothing.
            mac_a <= xfer ? in_a : '0;
            mac_b <= xfer ? in_b : '0;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            count <= len;
                            state <= CLEAR;
                        end else begin
                            res   <= '0;
                            state <= DONE;
                        end
                    end
                end
                CLEAR: state <= STREAM;
                STREAM: begin
                    if (xfer) begin
                        count <= count - 1'b1;
                        if (count == LEN_W'(1)) begin
                            drain_cnt <= DRAIN_W'(MAC_LAT);
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Last product reaches mac_out after MAC_LAT stages; wait one more.
                    if (drain_cnt == '0) begin
                        res   <= mac_out;
                        state <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer: a behavioural MAC closes the loop, the
// driver queues expected results, a negedge monitor pops and compares them.
module tb_mac_sequencer;

    localparam int DATA_W  = 8;
    localparam int ACC_W   = 16;
    localparam int LEN_W   = 8;
    localparam int MAC_LAT = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [DATA_W-1:0] mac_a;
    logic [DATA_W-1:0] mac_b;
    logic              mac_clr;
    logic [ACC_W-1:0]  mac_out;
    logic [ACC_W-1:0]  res;
    logic              res_valid;

    typedef struct {
        logic [ACC_W-1:0] res;
        int               lat;
        int               scyc;
    } exp_t;

    exp_t             sb[$];
    exp_t             e;
    int               errors = 0;
    int               checks = 0;
    int               cyc = 0;
    int               jobs_done = 0;
    int               clr_count = 0;
    int               rdy_count = 0;
    logic             prev_rv = 1'b0;
    logic [ACC_W-1:0] acc;

    mac_sequencer #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W), .MAC_LAT(MAC_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mac_a(mac_a), .mac_b(mac_b), .mac_clr(mac_clr), .mac_out(mac_out),
        .res(res), .res_valid(res_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-stage MAC with synchronous clear, wrapping at ACC_W bits.
    always @(posedge clk) begin
        if (mac_clr) acc <= '0;
        else         acc <= acc + ACC_W'(mac_a) * ACC_W'(mac_b);
    end
    assign mac_out = acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mac_clr)  clr_count++;
            if (in_ready) rdy_count++;
            if (res_valid) begin
                check("rv_one_cycle", 32'(prev_rv), 0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_res_valid: got res=%0d with no job queued", res);
                end else begin
                    e = sb.pop_front();
                    check("res", 32'(res), 32'(e.res));
                    check("latency", 32'(cyc - e.scyc + 1), 32'(e.lat));
                end
                jobs_done++;
            end
            prev_rv = res_valid;
        end else begin
            prev_rv = 1'b0;
        end
    end

    task automatic start_job(input logic [LEN_W-1:0] n, input logic [ACC_W-1:0] er,
                             input int el, input bit hold);
        @(negedge clk);
        start = 1'b1;
        len   = n;
        @(posedge clk);
        #1;
        sb.push_back('{er, el, cyc});
        clr_count = 0;
        rdy_count = 0;
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    task automatic send_pair(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (jobs_done < target && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("done_timeout", 32'(jobs_done), 32'(target));
    endtask

    task automatic send_ref_pairs();
        send_pair(8'd5, 8'd2);
        send_pair(8'd3, 8'd4);
        send_pair(8'd7, 8'd9);
        send_pair(8'd8, 8'd6);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        len      = '0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy",      32'(busy), 0);
        check("rst_in_ready",  32'(in_ready), 0);
        check("rst_mac_clr",   32'(mac_clr), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res",       32'(res), 0);
        check("rst_mac_a",     32'(mac_a), 0);
        check("rst_mac_b",     32'(mac_b), 0);
        rst = 1'b0;

        // Back-to-back pairs: 10+12+63+48 = 133, strobe at start+8.
        start_job(8'd4, 16'd133, 8, 1'b0);
        send_ref_pairs();
        check("ready_after_last", 32'(in_ready), 0);
        check("busy_in_drain", 32'(busy), 1);
        wait_done(1);
        check("clr_pulses", 32'(clr_count), 1);

        // Three-cycle stall between pairs 2 and 3 delays the strobe by 3.
        start_job(8'd4, 16'd133, 11, 1'b0);
        send_pair(8'd5, 8'd2);
        send_pair(8'd3, 8'd4);
        repeat (3) begin
            @(negedge clk);
            check("stall_mac_a", 32'(mac_a), 0);
            check("stall_mac_b", 32'(mac_b), 0);
        end
        send_pair(8'd7, 8'd9);
        send_pair(8'd8, 8'd6);
        wait_done(2);

        // Zero-length job goes straight to DONE.
        start_job(8'd0, 16'd0, 1, 1'b0);
        wait_done(3);
        check("len0_clr", 32'(clr_count), 0);
        check("len0_ready", 32'(rdy_count), 0);

        // Wraparound, then a fresh job must not inherit the old accumulation.
        start_job(8'd2, 16'd64514, 6, 1'b0);
        send_pair(8'd255, 8'd255);
        send_pair(8'd255, 8'd255);
        wait_done(4);
        start_job(8'd1, 16'd65025, 5, 1'b0);
        send_pair(8'd255, 8'd255);
        wait_done(5);

        // Reset mid-job abandons it without a strobe.
        start_job(8'd4, 16'd133, 8, 1'b0);
        send_pair(8'd5, 8'd2);
        send_pair(8'd3, 8'd4);
        rst = 1'b1;
        #1;
        check("midrst_busy",      32'(busy), 0);
        check("midrst_in_ready",  32'(in_ready), 0);
        check("midrst_mac_clr",   32'(mac_clr), 0);
        check("midrst_res_valid", 32'(res_valid), 0);
        check("midrst_res",       32'(res), 0);
        check("midrst_mac_a",     32'(mac_a), 0);
        check("midrst_mac_b",     32'(mac_b), 0);
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("no_rv_after_rst", 32'(jobs_done), 5);
        start_job(8'd4, 16'd133, 8, 1'b0);
        send_ref_pairs();
        wait_done(6);
        check("restart_clr_pulses", 32'(clr_count), 1);

        // start held high with len changed mid-job: one job, original length.
        start_job(8'd1, 16'd12, 5, 1'b1);
        len = 8'd0;
        send_pair(8'd3, 8'd4);
        wait_done(7);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("held_start_jobs", 32'(jobs_done), 7);
        check("held_start_idle", 32'(busy), 0);
        check("sb_empty", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
